wb_initiator: RTL and testbench

Single-transaction Wishbone classic-cycle master that drives the GPIO port peripheral (and any other WIDTH-data Wishbone slave on the same bus) from a simple valid/ready command stream. It accepts one read or write command at a time, runs the bus cycle with ack/err/rty handling and a timeout watchdog, and returns a response with read data and status. It sits between a sequencer or debug bridge and the peripheral bus.

---
 rtl/wb_initiator_if.sv | 55 +++++
 rtl/wb_initiator.sv | 168 ++++++++++++++++
 tb/tb_wb_initiator.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_initiator_if
//  Description : Command/response stream plus Wishbone classic bus bundle
//                seen by the wb_initiator master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_initiator_if #(
    parameter int WIDTH = 8
) ();
    // Command stream
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_adr;
    logic [WIDTH-1:0] cmd_dat;

    // Response stream
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_dat;
    logic [1:0]       rsp_status;

    // Wishbone classic bus
    logic [31:0]      wbm_adr_o;
    logic [WIDTH-1:0] wbm_dat_o;
    logic             wbm_we_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic [2:0]       wbm_cti_o;
    logic [1:0]       wbm_bte_o;
    logic [WIDTH-1:0] wbm_dat_i;
    logic             wbm_ack_i;
    logic             wbm_err_i;
    logic             wbm_rty_i;

    // View from the initiator
    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_cti_o, wbm_bte_o
    );

    // View from the command source and bus slave side
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_cti_o, wbm_bte_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : wb_initiator
//  Description : Single-transaction Wishbone classic-cycle master driven by a
//                valid/ready command stream. Handles ack/err/rty, retries with
//                a one-cycle gap, and a stb watchdog; returns data + status.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_initiator #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 3,
    parameter int DAT_LATENCY = 1
) (
    input  logic           wb_clk,
    input  logic           wb_rst,
    wb_initiator_if.master bus
);
    localparam int TO_W  = (TIMEOUT   > 0) ? $clog2(TIMEOUT + 1)   : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Value of the timeout counter on the edge that must abort
    localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUS     = 3'd1,
        S_CAPTURE = 3'd2,
        S_GAP     = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t           r_state;
    logic [31:0]      r_adr;
    logic [WIDTH-1:0] r_dat;
    logic             r_we;
    logic             r_cyc;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_dat;
    logic [1:0]       r_rsp_status;
    logic [TO_W-1:0]  r_to_cnt;
    logic [RTY_W-1:0] r_rty_cnt;

    // Transaction sequencer: all bus and response outputs come straight from here
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state      <= S_IDLE;
            r_adr        <= '0;
            r_dat        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_to_cnt     <= '0;
            r_rty_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_adr        <= bus.cmd_adr;
                        r_dat        <= bus.cmd_dat;
                        r_we         <= bus.cmd_we;
                        r_to_cnt     <= '0;
                        r_rty_cnt    <= '0;
                        r_rsp_dat    <= '0;
                        r_rsp_status <= ST_OK;
                        r_cmd_ready  <= 1'b0;
                        r_cyc        <= 1'b1;
                        r_state      <= S_BUS;
                    end
                end

                S_BUS: begin
                    // Termination priority: err > ack > rty > watchdog
                    if (bus.wbm_err_i) begin
                        r_cyc        <= 1'b0;
                        r_rsp_status <= ST_ERR;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (bus.wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        if (r_we) begin
                            r_rsp_status <= ST_OK;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (DAT_LATENCY == 0) begin
                            r_rsp_dat    <= bus.wbm_dat_i;
                            r_rsp_status <= ST_OK;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            // Registered-data slave: read data arrives one cycle later
                            r_state <= S_CAPTURE;
                        end
                    end else if (bus.wbm_rty_i) begin
                        r_cyc <= 1'b0;
                        if (r_rty_cnt != RTY_MAX) begin
                            r_rty_cnt <= r_rty_cnt + 1'b1;
                            r_state   <= S_GAP;
                        end else begin
                            r_rsp_status <= ST_RETRY;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (TIMEOUT != 0 && r_to_cnt == TO_LAST) begin
                        r_cyc        <= 1'b0;
                        r_rsp_status <= ST_TIMEOUT;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    r_rsp_dat    <= bus.wbm_dat_i;
                    r_rsp_status <= ST_OK;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end

                S_GAP: begin
                    // One idle cycle, then re-issue the same request with a fresh watchdog
                    r_to_cnt <= '0;
                    r_cyc    <= 1'b1;
                    r_state  <= S_BUS;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_dat    = r_rsp_dat;
    assign bus.rsp_status = r_rsp_status;
    assign bus.wbm_adr_o  = r_adr;
    assign bus.wbm_dat_o  = r_dat;
    assign bus.wbm_we_o   = r_we;
    assign bus.wbm_cyc_o  = r_cyc;
    assign bus.wbm_stb_o  = r_cyc;
    assign bus.wbm_cti_o  = 3'b000;
    assign bus.wbm_bte_o  = 2'b00;
endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_initiator
//  Description : Bench for wb_initiator. Two instances share one clock:
//                index 0 = registered-data slave, TIMEOUT=10;
//                index 1 = same-cycle data slave, watchdog disabled.
//                A scriptable Wishbone stub answers each one.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_initiator;

    typedef struct {
        int         d;       // which instance
        bit         we;
        int         idx;     // word index, byte address = idx*4
        logic [7:0] dat;
        int         ack_at;  // stb cycle of each attempt answered with ack/rty (0 = never)
        int         err_at;  // stb cycle of each attempt answered with err (0 = never)
        int         rty_n;   // number of attempts answered with rty instead of ack
        int         hold;    // cycles rsp_ready is held low after rsp_valid
        logic [1:0] st;      // expected status
        logic [7:0] rd;      // expected rsp_dat
        int         lat;     // expected cycles from accept edge to rsp_valid
        int         stbc;    // expected total stb-high cycles
        int         att;     // expected bus attempts
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_mem = 1'b0;

    logic        cmd_valid [2];
    logic        cmd_we    [2];
    logic [31:0] cmd_adr   [2];
    logic [7:0]  cmd_dat   [2];
    logic        rsp_ready [2];

    logic        cmd_ready  [2];
    logic        rsp_valid  [2];
    logic [7:0]  rsp_dat    [2];
    logic [1:0]  rsp_status [2];
    logic [31:0] wadr [2];
    logic [7:0]  wdat [2];
    logic        wwe  [2];
    logic        wcyc [2];
    logic        wstb [2];
    logic [2:0]  wcti [2];
    logic [1:0]  wbte [2];

    int cfg_ack [2];
    int cfg_err [2];
    int cfg_rty [2];
    bit cfg_junk [2];

    logic [7:0] model_mem [2][16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int d, input int i);
        if (i == 0) return (d == 0) ? 8'hA5 : 8'h3C;
        return 8'(32'h20 * (d + 1) + i);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DL_G = (g == 0) ? 1 : 0;
        localparam int TO_G = (g == 0) ? 10 : 0;

        wb_initiator_if #(.WIDTH(8)) bus ();

        wb_initiator #(
            .WIDTH(8), .TIMEOUT(TO_G), .MAX_RETRY(3), .DAT_LATENCY(DL_G)
        ) dut (
            .wb_clk (clk),
            .wb_rst (rst),
            .bus    (bus.master)
        );

        logic [7:0] mem [16];
        int         stb_cnt = 0;
        int         rty_cnt = 0;
        logic [7:0] rd_q;
        logic [7:0] noise;
        logic       hit_ack, hit_err, hit_rty, junk;
        logic [3:0] widx;

        assign bus.cmd_valid = cmd_valid[g];
        assign bus.cmd_we    = cmd_we[g];
        assign bus.cmd_adr   = cmd_adr[g];
        assign bus.cmd_dat   = cmd_dat[g];
        assign bus.rsp_ready = rsp_ready[g];

        assign cmd_ready[g]  = bus.cmd_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_dat[g]    = bus.rsp_dat;
        assign rsp_status[g] = bus.rsp_status;
        assign wadr[g] = bus.wbm_adr_o;
        assign wdat[g] = bus.wbm_dat_o;
        assign wwe[g]  = bus.wbm_we_o;
        assign wcyc[g] = bus.wbm_cyc_o;
        assign wstb[g] = bus.wbm_stb_o;
        assign wcti[g] = bus.wbm_cti_o;
        assign wbte[g] = bus.wbm_bte_o;

        assign widx = bus.wbm_adr_o[5:2];
        assign junk = cfg_junk[g] && !bus.wbm_stb_o;

        // Scripted slave answer for the current stb cycle of the current attempt
        always_comb begin
            hit_ack = 1'b0;
            hit_err = 1'b0;
            hit_rty = 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (cfg_err[g] != 0 && stb_cnt + 1 == cfg_err[g]) hit_err = 1'b1;
                if (cfg_ack[g] != 0 && stb_cnt + 1 == cfg_ack[g]) begin
                    if (rty_cnt < cfg_rty[g]) hit_rty = 1'b1;
                    else                      hit_ack = 1'b1;
                end
            end
        end

        assign bus.wbm_ack_i = hit_ack | junk;
        assign bus.wbm_err_i = hit_err | junk;
        assign bus.wbm_rty_i = hit_rty | junk;
        assign bus.wbm_dat_i = (DL_G == 1) ? rd_q : (hit_ack ? mem[widx] : noise);

        // Slave state: per-attempt stb counter, rty count, storage, read register
        always_ff @(posedge clk) begin
            noise   <= 8'($urandom);
            rd_q    <= hit_ack ? mem[widx] : 8'($urandom);
            stb_cnt <= bus.wbm_stb_o ? stb_cnt + 1 : 0;
            if (cmd_valid[g] && bus.cmd_ready) rty_cnt <= 0;
            else if (hit_rty)                  rty_cnt <= rty_cnt + 1;
            if (load_mem) begin
                for (int i = 0; i < 16; i++) mem[i] <= init_val(g, i);
            end else if (hit_ack && !hit_err && bus.wbm_we_o) begin
                mem[widx] <= bus.wbm_dat_o;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: outcome of a transaction derived from the bus rules
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        int to_lim, gaps, t, kind;
        to_lim = (v.d == 0) ? 10 : 0;
        r.stbc = 0; r.att = 0; r.st = 2'b00; gaps = 0;
        for (int k = 0; k <= 3; k++) begin
            r.att++;
            t = 1 << 30; kind = -1;
            if (v.err_at != 0) begin t = v.err_at; kind = 0; end
            if (v.ack_at != 0 && v.ack_at < t) begin t = v.ack_at; kind = 1; end
            if (to_lim != 0 && to_lim < t) begin t = to_lim; kind = 2; end
            r.stbc += t;
            if (kind == 0) begin r.st = 2'b01; break; end
            if (kind == 2) begin r.st = 2'b10; break; end
            if (k >= v.rty_n) begin r.st = 2'b00; break; end
            if (k == 3) begin r.st = 2'b11; break; end
            gaps++;
        end
        r.rd  = (r.st == 2'b00 && !v.we) ? model_mem[v.d][v.idx] : 8'h00;
        r.lat = 1 + r.stbc + gaps + ((r.st == 2'b00 && !v.we && v.d == 0) ? 1 : 0);
        return r;
    endfunction

    task automatic run_txn(input vec_t v, output logic [1:0] st, output logic [7:0] rd,
                           output int lat, output int stbc, output int att);
        int d, bus_bad, hold_bad;
        bit prev_stb, seen;
        d = v.d;
        cfg_ack[d] = v.ack_at; cfg_err[d] = v.err_at; cfg_rty[d] = v.rty_n;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready[d], 1);
        cmd_valid[d] = 1'b1; cmd_we[d] = v.we;
        cmd_adr[d] = 32'(v.idx) << 2; cmd_dat[d] = v.dat;
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        lat = 0; stbc = 0; att = 0; prev_stb = 0; bus_bad = 0; seen = 0;
        for (int k = 1; k <= 400; k++) begin
            if (k > 1) @(negedge clk);
            if (wcyc[d] !== wstb[d]) bus_bad++;
            if (wstb[d] === 1'b1) begin
                stbc++;
                if (!prev_stb) att++;
                if (wadr[d] !== (32'(v.idx) << 2) || wdat[d] !== v.dat || wwe[d] !== v.we ||
                    wcti[d] !== 3'b000 || wbte[d] !== 2'b00) bus_bad++;
            end
            prev_stb = (wstb[d] === 1'b1);
            if (rsp_valid[d] === 1'b1) begin lat = k; seen = 1; break; end
        end
        check("rsp_seen", seen, 1);
        check("bus_fields", bus_bad, 0);
        st = rsp_status[d]; rd = rsp_dat[d];
        hold_bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_dat[d] !== rd || rsp_status[d] !== st ||
                cmd_ready[d] !== 1'b0 || wcyc[d] !== 1'b0) hold_bad++;
        end
        if (v.hold > 0) check("hold_stable", hold_bad, 0);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_released", rsp_valid[d], 0);
        check("cmd_ready_back", cmd_ready[d], 1);
    endtask

    task automatic apply(input vec_t v);
        logic [1:0] st;
        logic [7:0] rd;
        int lat, stbc, att;
        run_txn(v, st, rd, lat, stbc, att);
        check("status", st, v.st);
        check("rsp_dat", rd, v.rd);
        check("latency", lat, v.lat);
        check("stb_cycles", stbc, v.stbc);
        check("attempts", att, v.att);
        if (v.st == 2'b00 && v.we) model_mem[v.d][v.idx] = v.dat;
    endtask

    vec_t tbl [16];

    initial begin
        int bad;
        vec_t v;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 0; cmd_we[d] = 0; cmd_adr[d] = 0; cmd_dat[d] = 0; rsp_ready[d] = 0;
            cfg_ack[d] = 0; cfg_err[d] = 0; cfg_rty[d] = 0; cfg_junk[d] = 0;
            for (int i = 0; i < 16; i++) model_mem[d][i] = init_val(d, i);
        end
        rst = 1'b1; load_mem = 1'b1;
        repeat (3) @(negedge clk);
        load_mem = 1'b0;

        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            check("rst_cmd_ready", cmd_ready[d], 1);
            check("rst_rsp_valid", rsp_valid[d], 0);
            check("rst_rsp_dat", rsp_dat[d], 0);
            check("rst_rsp_status", rsp_status[d], 0);
            check("rst_cyc_stb_we", {wcyc[d], wstb[d], wwe[d]}, 0);
            check("rst_adr_dat", {wadr[d], wdat[d]}, 0);
            check("rst_cti_bte", {wcti[d], wbte[d]}, 0);
        end
        rst = 1'b0;

        //          d we idx dat    ack err rty hold  st     rd   lat stbc att
        tbl[0]  = '{0, 1, 1, 8'hFF,  1, 0,  0, 5, 2'b00, 8'h00,  2,  1, 1};
        tbl[1]  = '{0, 0, 1, 8'h00,  1, 0,  0, 0, 2'b00, 8'hFF,  3,  1, 1};
        tbl[2]  = '{0, 0, 0, 8'h00,  1, 0,  0, 0, 2'b00, 8'hA5,  3,  1, 1};
        tbl[3]  = '{1, 0, 0, 8'h00,  1, 0,  0, 0, 2'b00, 8'h3C,  2,  1, 1};
        tbl[4]  = '{0, 0, 0, 8'h00,  2, 2,  0, 0, 2'b01, 8'h00,  3,  2, 1};
        tbl[5]  = '{0, 0, 0, 8'h00,  1, 0,  2, 0, 2'b00, 8'hA5,  7,  3, 3};
        tbl[6]  = '{0, 1, 2, 8'h5A,  1, 0, 99, 0, 2'b11, 8'h00,  8,  4, 4};
        tbl[7]  = '{0, 0, 0, 8'h00,  0, 0,  0, 0, 2'b10, 8'h00, 11, 10, 1};
        tbl[8]  = '{1, 1, 3, 8'h77,  3, 0,  0, 2, 2'b00, 8'h00,  4,  3, 1};
        tbl[9]  = '{1, 0, 3, 8'h00,  1, 0,  0, 0, 2'b00, 8'h77,  2,  1, 1};
        tbl[10] = '{0, 0, 0, 8'h00, 10, 0,  0, 0, 2'b00, 8'hA5, 12, 10, 1};
        tbl[11] = '{1, 1, 4, 8'h99,  0, 1,  0, 0, 2'b01, 8'h00,  2,  1, 1};
        tbl[12] = '{0, 0, 0, 8'h00, 12, 0,  0, 0, 2'b10, 8'h00, 11, 10, 1};
        tbl[13] = '{0, 0, 0, 8'h00,  7, 0,  1, 0, 2'b00, 8'hA5, 17, 14, 2};
        tbl[14] = '{1, 0, 2, 8'h00,  2, 0,  1, 0, 2'b00, 8'h42,  6,  4, 2};
        tbl[15] = '{0, 0, 2, 8'h00,  1, 0,  0, 0, 2'b00, 8'h22,  3,  1, 1};
        for (int i = 0; i < 16; i++) apply(tbl[i]);

        // Watchdog disabled: a silent slave keeps stb up indefinitely
        cfg_ack[1] = 0; cfg_err[1] = 0; cfg_rty[1] = 0; cfg_junk[1] = 0;
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_we[1] = 1'b0; cmd_adr[1] = 32'h0;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) @(negedge clk);
            if (wstb[1] !== 1'b1 || rsp_valid[1] !== 1'b0) bad++;
        end
        check("no_timeout_1000", bad, 0);

        // Reset in the middle of the bus cycle
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cyc_stb", {wcyc[1], wstb[1]}, 0);
        check("midrst_rsp_valid", rsp_valid[1], 0);
        check("midrst_cmd_ready", cmd_ready[1], 1);
        check("midrst_rsp", {rsp_dat[1], rsp_status[1]}, 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0 || wcyc[1] !== 1'b0 || cmd_ready[1] !== 1'b1) bad++;
        end
        check("no_stale_rsp", bad, 0);

        // Randomized transactions against the reference
        for (int n = 0; n < 60; n++) begin
            v.d      = $urandom_range(0, 1);
            v.we     = 1'($urandom_range(0, 1));
            v.idx    = $urandom_range(0, 15);
            v.dat    = 8'($urandom);
            v.ack_at = $urandom_range(0, 12);
            if (v.d == 1 && v.ack_at == 0) v.ack_at = 1;
            v.err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            v.rty_n  = $urandom_range(0, 5);
            v.hold   = $urandom_range(0, 3);
            cfg_junk[v.d] = 1'($urandom_range(0, 1));
            v = predict(v);
            apply(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
